fir_out_reader: RTL and testbench

Output-side reader for the DSP FIR datapath. It captures the 54-bit accumulator result (`dout`) whenever the filter flags it valid, then scales, rounds and saturates it to an 18-bit sample. Samples are buffered in a small FIFO and presented to downstream logic on a valid/ready stream. It is the consumer counterpart of the `write`/`adr_in`/`x_in` sample-loading path that feeds the filter.

---
 rtl/fir_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/fir_out_reader.sv | 103 ++++++++++
 tb/tb_fir_out_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, sample type and the scale/round/saturate helper
// used by the FIR output path.
package fir_pkg;

   localparam int unsigned FIR_DIN_W  = 54;
   localparam int unsigned FIR_DOUT_W = 18;

   // Working width of sat_shift; any DIN_W+1 up to this width is exact.
   localparam int unsigned FN_W = 128;

   typedef logic signed [FIR_DOUT_W-1:0] sample_t;

   // Adds rnd, arithmetic-shifts right by shift, saturates to a signed
   // dout_w-bit range. Returns {sat, sample} right-aligned: the sample sits
   // in bits [dout_w-1:0], the clip flag in bit dout_w, higher bits are zero.
   function automatic logic [FN_W:0] sat_shift(
      input logic signed [FN_W-1:0] d,
      input logic signed [FN_W-1:0] rnd,
      input int unsigned            shift,
      input int unsigned            dout_w
   );
      logic signed [FN_W-1:0] t;
      logic signed [FN_W-1:0] hi;
      logic signed [FN_W-1:0] lo;
      logic signed [FN_W-1:0] val;
      logic        [FN_W-1:0] mask;
      logic                   sat;
      logic        [FN_W:0]   r;
      t    = (d + rnd) >>> shift;
      hi   = $signed((FN_W'(1) << (dout_w - 1)) - FN_W'(1));
      lo   = ~hi;
      mask = (FN_W'(1) << dout_w) - FN_W'(1);
      sat  = 1'b0;
      val  = t;
      if (t > hi) begin
         sat = 1'b1;
         val = hi;
      end else if (t < lo) begin
         sat = 1'b1;
         val = lo;
      end
      r         = {1'b0, FN_W'(val) & mask};
      r[dout_w] = sat;
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered head and flags.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write request and data (dropped when full without pop)
//   pop             read request; honoured only while not empty
//   rdata           head entry (0 while empty)
//   full, empty     registered occupancy flags
//   level           registered occupancy, 0..DEPTH
module sync_fifo #(
   parameter int unsigned W     = 19,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [AW:0]   level_n;
   logic [W-1:0]  head_n;
   logic          do_push, do_pop;

   // Next-state: a pop frees a slot, so push+pop while full both proceed.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      if (do_push) wr_ptr_n = wr_ptr + AW'(1);
      if (do_pop)  rd_ptr_n = rd_ptr + AW'(1);
      level_n  = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // Head bypass: the entry being written may become the new head.
      if (level_n == '0)
         head_n = '0;
      else if (do_push && (wr_ptr == rd_ptr_n))
         head_n = wdata;
      else
         head_n = mem[rd_ptr_n];
   end

   // Storage array, not reset; only entries below level are ever presented.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers, level, flags and head register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         rdata  <= '0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         level  <= level_n;
         full   <= (level_n == (AW+1)'(DEPTH));
         empty  <= (level_n == '0);
         rdata  <= head_n;
      end
   end

endmodule

// File: rtl/fir_out_reader.sv
// fir_out_reader: captures FIR accumulator results, scales/rounds/saturates
// them to DOUT_W-bit samples and streams them out through a FWFT FIFO.
// Build option: define FIR_RD_ROUND_EN for round-half-up; otherwise the
// shift truncates toward -inf and no rounding adder is built.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   ena, din_valid, din  capture enable, result strobe, signed result
//   m_valid, m_ready     output stream handshake
//   m_data, m_sat        scaled sample and its clip flag
//   level                FIFO occupancy
//   overflow, clr_ovf    sticky drop flag and its synchronous clear
module fir_out_reader
   import fir_pkg::*;
#(
   parameter int unsigned DIN_W  = FIR_DIN_W,
   parameter int unsigned DOUT_W = FIR_DOUT_W,
   parameter int unsigned SHIFT  = 17,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     din_valid,
   input  logic [DIN_W-1:0]         din,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DOUT_W-1:0]        m_data,
   output logic                     m_sat,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf
);

`ifdef FIR_RD_ROUND_EN
   localparam logic signed [FN_W-1:0] RND = $signed(FN_W'(1) << (SHIFT - 1));
`else
   localparam logic signed [FN_W-1:0] RND = '0;
`endif

   logic                    s1_v;
   logic signed [DIN_W-1:0] s1_d;
   logic                    s2_v;
   logic [DOUT_W:0]         s2_d;
   logic [DOUT_W:0]         s2_next_c;
   logic [DOUT_W:0]         fifo_rdata;
   logic                    fifo_full, fifo_empty;
   logic                    ovf_set_c;

   // Scale stage combinational result, {sat, sample}.
   always_comb begin
      s2_next_c = (DOUT_W+1)'(sat_shift(FN_W'(s1_d), RND, SHIFT, DOUT_W));
   end

   // S1 capture and S2 scale registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_d <= '0;
         s2_v <= 1'b0;
         s2_d <= '0;
      end else begin
         s1_v <= ena && din_valid;
         if (ena && din_valid) s1_d <= din;
         s2_v <= s1_v;
         if (s1_v) s2_d <= s2_next_c;
      end
   end

   sync_fifo #(
      .W     (DOUT_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s2_v),
      .wdata (s2_d),
      .pop   (m_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // A full FIFO is never empty, so m_ready alone decides whether a slot frees.
   always_comb begin
      ovf_set_c = s2_v && fifo_full && !m_ready;
   end

   // Sticky overflow; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (ovf_set_c)
         overflow <= 1'b1;
      else if (clr_ovf)
         overflow <= 1'b0;
   end

   assign m_valid = !fifo_empty;
   assign m_sat   = fifo_rdata[DOUT_W];
   assign m_data  = fifo_rdata[DOUT_W-1:0];

endmodule

// File: tb/tb_fir_out_reader.sv
// tb_fir_out_reader: directed stimulus with a scoreboard queue; a monitor
// pops and compares every accepted output sample.
module tb_fir_out_reader;

   localparam int unsigned DIN_W  = 54;
   localparam int unsigned DOUT_W = 18;
   localparam int unsigned DEPTH  = 16;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    ena;
   logic                    din_valid;
   logic [DIN_W-1:0]        din;
   logic                    m_valid;
   logic                    m_ready;
   logic [DOUT_W-1:0]       m_data;
   logic                    m_sat;
   logic [$clog2(DEPTH):0]  level;
   logic                    overflow;
   logic                    clr_ovf;

   int n_vec = 0;
   int n_err = 0;
   logic [DOUT_W:0] exp_q[$];

   always #5 clk = ~clk;

   fir_out_reader #(
      .DIN_W  (DIN_W),
      .DOUT_W (DOUT_W),
      .SHIFT  (17),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .din_valid (din_valid),
      .din       (din),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_sat     (m_sat),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   function automatic logic [DOUT_W:0] mk(input int v, input bit s);
      return {s, DOUT_W'(v)};
   endfunction

   function automatic longint sc(input longint k);
      return k * 131072;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one valid result; leaves din_valid high for back-to-back use.
   task automatic send(input longint v, input int e, input bit s, input bit keep);
      ena       = 1'b1;
      din_valid = 1'b1;
      din       = DIN_W'(v);
      if (keep) exp_q.push_back(mk(e, s));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Latency probe: after a send, m_valid low after N and N+1, high after N+2.
   task automatic latency(input string name);
      din_valid = 1'b0;
      @(negedge clk);
      check({name, "_lat_n0"}, longint'(m_valid), 0);
      @(posedge clk); @(negedge clk);
      check({name, "_lat_n1"}, longint'(m_valid), 0);
      @(posedge clk); @(negedge clk);
      check({name, "_lat_n2"}, longint'(m_valid), 1);
      @(posedge clk); #1;
   endtask

   // Monitor: every handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: got sat=%0b data=%0d expected no sample",
                     m_sat, $signed(m_data));
         end else begin
            logic [DOUT_W:0] e;
            e = exp_q.pop_front();
            if ({m_sat, m_data} !== e) begin
               n_err++;
               $display("FAIL out_sample: got sat=%0b data=%0d expected sat=%0b data=%0d",
                        m_sat, $signed(m_data), e[DOUT_W], $signed(e[DOUT_W-1:0]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      ena       = 1'b0;
      din_valid = 1'b0;
      din       = '0;
      m_ready   = 1'b1;
      clr_ovf   = 1'b0;
      #12;
      check("rst_m_valid", longint'(m_valid), 0);
      check("rst_level", longint'(level), 0);
      check("rst_m_data", longint'(m_data), 0);
      check("rst_m_sat", longint'(m_sat), 0);
      check("rst_overflow", longint'(overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Scaling and first-sample latency.
      send(sc(1000), 1000, 1'b0, 1'b1);
      latency("scale");
      idle(2);

      // Rounding of exact half LSB, positive and negative.
`ifdef FIR_RD_ROUND_EN
      send(65536, 1, 1'b0, 1'b1);
      send(-65536, 0, 1'b0, 1'b1);
`else
      send(65536, 0, 1'b0, 1'b1);
      send(-65536, -1, 1'b0, 1'b1);
`endif
      idle(5);

      // Saturation and the range edges, back to back.
      send(longint'(1) <<< 40, 131071, 1'b1, 1'b1);
      send(-(longint'(1) <<< 40), -131072, 1'b1, 1'b1);
      send(sc(131071), 131071, 1'b0, 1'b1);
      send(sc(131072), 131071, 1'b1, 1'b1);
      send(sc(-131072), -131072, 1'b0, 1'b1);
      send(sc(-131073), -131072, 1'b1, 1'b1);
      idle(5);

      // ena low gates new captures but lets the in-flight sample finish.
      send(sc(3), 3, 1'b0, 1'b1);
      ena       = 1'b0;
      din_valid = 1'b1;
      din       = DIN_W'(sc(5));
      repeat (2) begin
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      ena       = 1'b1;
      idle(5);
      check("ena_level", longint'(level), 0);
      check("ena_q_empty", longint'(exp_q.size()), 0);

      // Fill to full and overflow by one.
      m_ready = 1'b0;
      for (int k = 1; k <= 17; k++) send(sc(k), k, 1'b0, k <= 16);
      idle(4);
      check("full_level", longint'(level), 16);
      check("full_overflow", longint'(overflow), 1);
      check("full_m_valid", longint'(m_valid), 1);
      check("full_head", longint'($signed(m_data)), 1);
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      check("clr_overflow", longint'(overflow), 0);
      check("clr_level", longint'(level), 16);

      // Push and pop on the same edge while full.
      send(sc(99), 99, 1'b0, 1'b1);
      din_valid = 1'b0;
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      check("pp_level", longint'(level), 16);
      check("pp_overflow", longint'(overflow), 0);
      m_ready = 1'b1;
      for (int i = 0; i < 40 && m_valid; i++) begin
         @(posedge clk); #1;
      end
      check("drain_level", longint'(level), 0);
      check("drain_q_empty", longint'(exp_q.size()), 0);

      // Reset mid-stream with samples buffered.
      m_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send(sc(k + 10), k + 10, 1'b0, 1'b1);
      idle(4);
      check("pre_rst_level", longint'(level), 5);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
      check("mid_rst_m_valid", longint'(m_valid), 0);
      check("mid_rst_level", longint'(level), 0);
      check("mid_rst_m_data", longint'(m_data), 0);
      exp_q.delete();
      m_ready = 1'b1;
      @(posedge clk); #1;
      send(sc(7), 7, 1'b0, 1'b1);
      latency("post_rst");
      idle(3);
      check("end_q_empty", longint'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
